// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl -- eight-key debouncer with a pending/mask interrupt block.
//
// The raw active-low key lines are synchronised and sampled once every
// TICK_DIV clocks. A key's debounced state flips only after STABLE_N
// consecutive ticks that all disagree with it. A debounced press (1->0)
// latches a pending bit. The pending bits are write-1-to-clear, are gated
// by a mask register, and drive a level interrupt.
//
// Ports
//   clk       in   1       system clock, rising edge
//   reset_n   in   1       asynchronous active-low reset
//   Addr      in   [31:2]  word address from the bus bridge
//   WE        in   1       write strobe
//   Din       in   32      write data (only [7:0] used)
//   Dout      out  32      combinational read data
//   user_key  in   8       raw asynchronous keys, 0 = pressed
//   irq       out  1       level interrupt, |(PEND & MASK)
//
// Register map (byte address {Addr,2'b00})
//   0x7F40 KEY  RO   debounced key state
//   0x7F44 PEND R/W1C pending press events
//   0x7F48 MASK R/W  interrupt enables
module key_irq_ctrl #(
  parameter int TICK_DIV = 20000,
  parameter int STABLE_N = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [7:0]  user_key,
  output logic        irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Counts never hold STABLE_N itself: reaching it settles and clears.
  localparam int SW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;

  localparam logic [29:0] A_KEY  = 30'h0000_1FD0;
  localparam logic [29:0] A_PEND = 30'h0000_1FD1;
  localparam logic [29:0] A_MASK = 30'h0000_1FD2;

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_deb;
  logic [SW-1:0] r_stab [8];
  logic [7:0]    r_pend;
  logic [7:0]    r_mask;

  logic          w_tick;
  logic [7:0]    w_diff;
  logic [7:0]    w_settle;
  logic [7:0]    w_press;
  logic [7:0]    w_clr;
  logic          w_sel_key;
  logic          w_sel_pend;
  logic          w_sel_mask;
  logic          w_unused_din;

  assign w_unused_din = ^Din[31:8];

  // Synchroniser stage; resets to "all released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= user_key;
      r_sync2 <= r_sync1;
    end
  end

  // Sample tick generator stage.
  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // A key settles when this tick is the STABLE_N-th consecutive disagreement.
  always_comb begin
    w_diff   = r_sync2 ^ r_deb;
    w_settle = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_settle[i] = w_tick & w_diff[i] & (r_stab[i] == SW'(STABLE_N - 1));
    end
    // Settling to 0 means the debounced key went 1->0: a press.
    w_press = w_settle & ~r_sync2;
  end

  // Debounce stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= 8'hFF;
      for (int i = 0; i < 8; i++) begin
        r_stab[i] <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < 8; i++) begin
        if (w_settle[i]) begin
          r_deb[i]  <= r_sync2[i];
          r_stab[i] <= '0;
        end else if (w_diff[i]) begin
          r_stab[i] <= r_stab[i] + SW'(1);
        end else begin
          r_stab[i] <= '0;
        end
      end
    end
  end

  // Register file stage.
  assign w_sel_key  = (Addr == A_KEY);
  assign w_sel_pend = (Addr == A_PEND);
  assign w_sel_mask = (Addr == A_MASK);
  assign w_clr      = (WE && w_sel_pend) ? Din[7:0] : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 8'h00;
      r_mask <= 8'h00;
    end else begin
      // Set is ORed in after the clear so a coincident press survives.
      r_pend <= (r_pend & ~w_clr) | w_press;
      if (WE && w_sel_mask) begin
        r_mask <= Din[7:0];
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    if (w_sel_key) begin
      Dout = {24'd0, r_deb};
    end else if (w_sel_pend) begin
      Dout = {24'd0, r_pend};
    end else if (w_sel_mask) begin
      Dout = {24'd0, r_mask};
    end
  end

  assign irq = |(r_pend & r_mask);

endmodule
